// File: rtl/ifetch_stage_if.sv
// rtl/ifetch_stage_if.sv - control-unit and imem signal bundle for ifetch_stage
// master = control unit plus imem side, slave = the fetch stage itself.
interface ifetch_stage_if;
  logic        fetch_req;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_next_in;
  logic [31:0] imem_addr;
  logic        imem_read_en_;
  logic [31:0] imem_instr;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_done;
  logic        fetch_fault;
  logic        halted;

  modport master (
    output fetch_req,
    output stall,
    output pc_load,
    output pc_next_in,
    output imem_instr,
    input  imem_addr,
    input  imem_read_en_,
    input  ir_out,
    input  ir_pc,
    input  pc_out,
    input  pc_plus4,
    input  fetch_done,
    input  fetch_fault,
    input  halted
  );

  modport slave (
    input  fetch_req,
    input  stall,
    input  pc_load,
    input  pc_next_in,
    input  imem_instr,
    output imem_addr,
    output imem_read_en_,
    output ir_out,
    output ir_pc,
    output pc_out,
    output pc_plus4,
    output fetch_done,
    output fetch_fault,
    output halted
  );
endinterface

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - multi-cycle fetch stage: owns PC, sequences imem reads, captures IR
// Halt-on-opcode 6'b111111 is built only when IFETCH_HALT_DETECT_EN is defined.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_00F8,
  parameter int unsigned IMEM_BYTES = 351
) (
  input logic           clk,
  input logic           rst,
  ifetch_stage_if.slave bus
);

  // Highest PC whose 4-byte word still lies fully inside imem.
  localparam logic [31:0] LAST_FETCH_PC = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] ir_q;
  logic [31:0] ir_pc_q;
  logic        rd_en_n_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] pc_inc;
  logic        fetch_legal;

  assign pc_inc      = pc_q + 32'd4;
  assign fetch_legal = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_FETCH_PC);

`ifdef IFETCH_HALT_DETECT_EN
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  logic halted_q;
  logic halt_hit;
  assign halt_hit   = (bus.imem_instr[31:26] == HALT_OPCODE);
  assign bus.halted = halted_q;
`else
  assign bus.halted = 1'b0;
`endif

  // pc only moves on a load while idle or on the capture edge.
  always_comb begin
    pc_d = pc_q;
    case (state_q)
      S_IDLE:    if (bus.pc_load) pc_d = bus.pc_next_in;
      S_CAPTURE: pc_d = pc_inc;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      ir_pc_q   <= 32'h0;
      rd_en_n_q <= 1'b1;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!bus.pc_load && bus.fetch_req) begin
            if (fetch_legal) begin
              state_q   <= S_ISSUE;
              rd_en_n_q <= 1'b0;
            end else begin
              fault_q   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (!bus.stall) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          ir_q      <= bus.imem_instr;
          ir_pc_q   <= pc_q;
          done_q    <= 1'b1;
          rd_en_n_q <= 1'b1;
`ifdef IFETCH_HALT_DETECT_EN
          if (halt_hit) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
          end
`else
          state_q   <= S_IDLE;
`endif
        end
`ifdef IFETCH_HALT_DETECT_EN
        S_HALT: begin
          state_q   <= S_HALT;
          rd_en_n_q <= 1'b1;
        end
`endif
        default: begin
          state_q   <= S_IDLE;
          rd_en_n_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.imem_read_en_ = rd_en_n_q;
  assign bus.ir_out        = ir_q;
  assign bus.ir_pc         = ir_pc_q;
  assign bus.pc_out        = pc_q;
  assign bus.pc_plus4      = pc_inc;
  assign bus.fetch_done    = done_q;
  assign bus.fetch_fault   = fault_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - self-checking bench for ifetch_stage with a byte-array imem model
// Honours IFETCH_HALT_DETECT_EN when computing expected halt behaviour.
module tb_ifetch_stage;
  localparam logic [31:0] MEM_BYTES = 32'd351;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_stage_if bus ();

  ifetch_stage #(
    .RESET_PC  (32'h0000_00F8),
    .IMEM_BYTES(351)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Little-endian byte-addressed imem; bytes past the end read as zero.
  logic [7:0]  mem [0:511];
  logic [31:0] ba0, ba1, ba2, ba3;
  assign ba0 = bus.imem_addr;
  assign ba1 = bus.imem_addr + 32'd1;
  assign ba2 = bus.imem_addr + 32'd2;
  assign ba3 = bus.imem_addr + 32'd3;
  assign bus.imem_instr = {(ba3 < MEM_BYTES) ? mem[ba3[8:0]] : 8'h00,
                           (ba2 < MEM_BYTES) ? mem[ba2[8:0]] : 8'h00,
                           (ba1 < MEM_BYTES) ? mem[ba1[8:0]] : 8'h00,
                           (ba0 < MEM_BYTES) ? mem[ba0[8:0]] : 8'h00};

  logic [31:0] m_pc, m_ir, m_ir_pc;
  logic        m_halted;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      if (a + 32'(k) < MEM_BYTES) w[8*k +: 8] = mem[9'(a + 32'(k))];
    return w;
  endfunction

  function automatic logic ref_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a + 32'd3 <= MEM_BYTES - 32'd1);
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[9'(a + 32'(k))] = w[8*k +: 8];
  endtask

  task automatic model_fetch();
    if (!m_halted && ref_legal(m_pc)) begin
      m_ir    = ref_word(m_pc);
      m_ir_pc = m_pc;
      m_pc    = m_pc + 32'd4;
`ifdef IFETCH_HALT_DETECT_EN
      if (m_ir[31:26] == 6'h3F) m_halted = 1'b1;
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a);
    bus.pc_load    = 1'b1;
    bus.pc_next_in = a;
    step();
    bus.pc_load    = 1'b0;
    if (!m_halted) m_pc = a;
  endtask

  // One fetch request; stall held for the first n_stall edges after the request edge.
  task automatic do_fetch(input int n_stall, output int lat, output int low_cnt,
                          output logic moved, output logic done_seen, output logic fault_seen);
    logic [31:0] a0;
    lat = 0; low_cnt = 0; moved = 1'b0; done_seen = 1'b0; fault_seen = 1'b0;
    a0 = bus.imem_addr;
    bus.fetch_req = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      bus.fetch_req = 1'b0;
      bus.stall = (c <= n_stall);
      if (bus.imem_read_en_ === 1'b0) low_cnt++;
      if (bus.fetch_done === 1'b1) begin lat = c; done_seen = 1'b1; break; end
      if (bus.imem_addr !== a0) moved = 1'b1;
      if (bus.fetch_fault === 1'b1) begin lat = c; fault_seen = 1'b1; break; end
    end
    bus.stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.stall = 1'b0; bus.pc_load = 1'b0; bus.pc_next_in = 32'h0;
    step(); step();
    n_cmp++; if (bus.pc_out !== 32'h0000_00F8) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus.pc_out, 32'h0000_00F8); end
    n_cmp++; if (bus.imem_addr !== 32'h0000_00F8) begin n_bad++; $display("FAIL reset_addr: got %h want %h", bus.imem_addr, 32'h0000_00F8); end
    n_cmp++; if (bus.pc_plus4 !== 32'h0000_00FC) begin n_bad++; $display("FAIL reset_pc4: got %h want %h", bus.pc_plus4, 32'h0000_00FC); end
    n_cmp++; if (bus.ir_out !== 32'h0) begin n_bad++; $display("FAIL reset_ir: got %h want 0", bus.ir_out); end
    n_cmp++; if (bus.ir_pc !== 32'h0) begin n_bad++; $display("FAIL reset_irpc: got %h want 0", bus.ir_pc); end
    n_cmp++; if ({bus.fetch_done, bus.fetch_fault, bus.halted} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.fetch_done, bus.fetch_fault, bus.halted}); end
    n_cmp++; if (bus.imem_read_en_ !== 1'b1) begin n_bad++; $display("FAIL reset_rden: got %b want 1", bus.imem_read_en_); end
    rst = 1'b0;
    m_pc = 32'h0000_00F8; m_ir = 32'h0; m_ir_pc = 32'h0; m_halted = 1'b0;
  endtask

  task automatic test_basic_fetch();
    int lat, low; logic mv, dn, ft;
    put_word(32'h0000_00F8, 32'hE000_0044);
    do_fetch(0, lat, low, mv, dn, ft);
    model_fetch();
    n_cmp++; if (dn !== 1'b1 || lat != 3) begin n_bad++; $display("FAIL basic_latency: got done=%b lat=%0d want done=1 lat=3", dn, lat); end
    n_cmp++; if (low != 2) begin n_bad++; $display("FAIL basic_rden_low: got %0d want 2", low); end
    n_cmp++; if (bus.fetch_fault !== 1'b0) begin n_bad++; $display("FAIL basic_fault_with_done: got %b want 0", bus.fetch_fault); end
    n_cmp++; if (bus.ir_out !== m_ir) begin n_bad++; $display("FAIL basic_ir: got %h want %h", bus.ir_out, m_ir); end
    n_cmp++; if (bus.ir_pc !== m_ir_pc) begin n_bad++; $display("FAIL basic_irpc: got %h want %h", bus.ir_pc, m_ir_pc); end
    n_cmp++; if (bus.pc_out !== m_pc || bus.pc_plus4 !== m_pc + 32'd4) begin n_bad++; $display("FAIL basic_pc: got %h/%h want %h", bus.pc_out, bus.pc_plus4, m_pc); end
    step();
    n_cmp++; if (bus.fetch_done !== 1'b0 || bus.imem_read_en_ !== 1'b1) begin n_bad++; $display("FAIL basic_done_width: got done=%b rden=%b want 0/1", bus.fetch_done, bus.imem_read_en_); end
    n_cmp++; if (bus.ir_out !== m_ir) begin n_bad++; $display("FAIL basic_ir_hold: got %h want %h", bus.ir_out, m_ir); end
  endtask

  task automatic test_branch_load();
    int lat, low, act; logic mv, dn, ft;
    bus.pc_load = 1'b1; bus.pc_next_in = 32'h0000_0110; bus.fetch_req = 1'b1;
    step();
    bus.pc_load = 1'b0; bus.fetch_req = 1'b0;
    m_pc = 32'h0000_0110;
    act = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.fetch_done !== 1'b0 || bus.fetch_fault !== 1'b0 || bus.imem_read_en_ !== 1'b1) act++;
      step();
    end
    n_cmp++; if (bus.pc_out !== m_pc) begin n_bad++; $display("FAIL branch_pc: got %h want %h", bus.pc_out, m_pc); end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL branch_no_fetch: got %0d active cycles want 0", act); end
    put_word(32'h0000_0110, 32'h0801_0030);
    do_fetch(0, lat, low, mv, dn, ft);
    model_fetch();
    n_cmp++; if (dn !== 1'b1 || bus.ir_out !== m_ir) begin n_bad++; $display("FAIL branch_ir: got %h want %h", bus.ir_out, m_ir); end
    n_cmp++; if (bus.pc_out !== m_pc) begin n_bad++; $display("FAIL branch_pc4: got %h want %h", bus.pc_out, m_pc); end
  endtask

  task automatic test_stall();
    int lat, low; logic mv, dn, ft;
    put_word(m_pc, $urandom & 32'h7FFF_FFFF);
    do_fetch(4, lat, low, mv, dn, ft);
    model_fetch();
    n_cmp++; if (dn !== 1'b1 || lat != 7) begin n_bad++; $display("FAIL stall_latency: got done=%b lat=%0d want done=1 lat=7", dn, lat); end
    n_cmp++; if (low != 6) begin n_bad++; $display("FAIL stall_rden_low: got %0d want 6", low); end
    n_cmp++; if (mv !== 1'b0) begin n_bad++; $display("FAIL stall_addr_stable: got moved=%b want 0", mv); end
    n_cmp++; if (bus.ir_out !== m_ir || bus.pc_out !== m_pc) begin n_bad++; $display("FAIL stall_result: got ir=%h pc=%h want ir=%h pc=%h", bus.ir_out, bus.pc_out, m_ir, m_pc); end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    int lat, low; logic mv, dn, ft, lg;
    addrs[0] = 32'h0000_0102; addrs[1] = 32'h0000_015C; addrs[2] = 32'h0000_0158;
    for (int i = 0; i < 3; i++) begin
      do_load(addrs[i]);
      lg = ref_legal(addrs[i]);
      do_fetch(0, lat, low, mv, dn, ft);
      model_fetch();
      n_cmp++; if (ft !== !lg || dn !== lg) begin n_bad++; $display("FAIL fault_kind@%h: got fault=%b done=%b want fault=%b", addrs[i], ft, dn, !lg); end
      n_cmp++; if (lat != (lg ? 3 : 1) || low != (lg ? 2 : 0)) begin n_bad++; $display("FAIL fault_timing@%h: got lat=%0d low=%0d", addrs[i], lat, low); end
      n_cmp++; if (bus.ir_out !== m_ir || bus.pc_out !== m_pc) begin n_bad++; $display("FAIL fault_state@%h: got ir=%h pc=%h want ir=%h pc=%h", addrs[i], bus.ir_out, bus.pc_out, m_ir, m_pc); end
      step();
      n_cmp++; if (bus.fetch_fault !== 1'b0 || bus.fetch_done !== 1'b0) begin n_bad++; $display("FAIL fault_pulse@%h: got fault=%b done=%b want 0/0", addrs[i], bus.fetch_fault, bus.fetch_done); end
    end
  endtask

  task automatic test_ignored_in_flight();
    do_load(32'h0000_0020);
    bus.fetch_req = 1'b1;
    step();
    bus.pc_load = 1'b1; bus.pc_next_in = 32'h0000_0080;
    step();
    step();
    bus.pc_load = 1'b0; bus.fetch_req = 1'b0;
    model_fetch();
    n_cmp++; if (bus.fetch_done !== 1'b1 || bus.pc_out !== m_pc || bus.ir_out !== m_ir) begin n_bad++; $display("FAIL ignore_load: got done=%b pc=%h ir=%h want 1 pc=%h ir=%h", bus.fetch_done, bus.pc_out, bus.ir_out, m_pc, m_ir); end
    step();
    n_cmp++; if (bus.imem_read_en_ !== 1'b1 || bus.pc_out !== m_pc || bus.fetch_done !== 1'b0) begin n_bad++; $display("FAIL ignore_queue: got rden=%b pc=%h done=%b want 1 pc=%h 0", bus.imem_read_en_, bus.pc_out, bus.fetch_done, m_pc); end
  endtask

  task automatic test_random();
    int lat, low, ns, r; logic mv, dn, ft, lg;
    logic [31:0] a;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 9);
        if (r < 7)      a = 32'(4 * $urandom_range(0, 86));
        else if (r < 8) a = 32'(4 * $urandom_range(0, 86) + $urandom_range(1, 3));
        else            a = 32'(4 * $urandom_range(87, 127));
        do_load(a);
        n_cmp++; if (bus.pc_out !== m_pc) begin n_bad++; $display("FAIL rnd_load[%0d]: got %h want %h", it, bus.pc_out, m_pc); end
      end
      lg = ref_legal(m_pc);
      ns = $urandom_range(0, 3);
      do_fetch(ns, lat, low, mv, dn, ft);
      model_fetch();
      n_cmp++; if (lat != (lg ? 3 + ns : 1) || dn !== lg || ft !== !lg) begin n_bad++; $display("FAIL rnd_timing[%0d]: got lat=%0d done=%b fault=%b want lat=%0d legal=%b", it, lat, dn, ft, lg ? 3 + ns : 1, lg); end
      n_cmp++; if (bus.ir_out !== m_ir || bus.ir_pc !== m_ir_pc || bus.pc_out !== m_pc) begin n_bad++; $display("FAIL rnd_state[%0d]: got ir=%h irpc=%h pc=%h want %h %h %h", it, bus.ir_out, bus.ir_pc, bus.pc_out, m_ir, m_ir_pc, m_pc); end
      step();
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_load(32'h0000_0040);
    bus.fetch_req = 1'b1;
    step();
    bus.fetch_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_pc = 32'h0000_00F8; m_ir = 32'h0; m_ir_pc = 32'h0;
    n_cmp++; if (bus.pc_out !== m_pc || bus.ir_out !== m_ir || bus.ir_pc !== m_ir_pc) begin n_bad++; $display("FAIL midrst_state: got pc=%h ir=%h irpc=%h want %h 0 0", bus.pc_out, bus.ir_out, bus.ir_pc, m_pc); end
    n_cmp++; if (bus.fetch_done !== 1'b0 || bus.imem_read_en_ !== 1'b1) begin n_bad++; $display("FAIL midrst_flags: got done=%b rden=%b want 0/1", bus.fetch_done, bus.imem_read_en_); end
    step();
    n_cmp++; if (bus.fetch_done !== 1'b0 || bus.pc_out !== m_pc) begin n_bad++; $display("FAIL midrst_after: got done=%b pc=%h want 0 %h", bus.fetch_done, bus.pc_out, m_pc); end
  endtask

  task automatic test_halt();
    int lat, low; logic mv, dn, ft;
    put_word(32'h0000_0140, 32'hFC00_0000);
    put_word(32'h0000_0144, 32'h1234_5678);
    do_load(32'h0000_0140);
    do_fetch(0, lat, low, mv, dn, ft);
    model_fetch();
    n_cmp++; if (dn !== 1'b1 || bus.ir_out !== m_ir || bus.pc_out !== m_pc) begin n_bad++; $display("FAIL halt_fetch: got done=%b ir=%h pc=%h want 1 %h %h", dn, bus.ir_out, bus.pc_out, m_ir, m_pc); end
    n_cmp++; if (bus.halted !== m_halted) begin n_bad++; $display("FAIL halt_flag: got %b want %b", bus.halted, m_halted); end
    step();
    do_fetch(0, lat, low, mv, dn, ft);
    model_fetch();
    n_cmp++; if (dn !== !m_halted || low != (m_halted ? 0 : 2)) begin n_bad++; $display("FAIL halt_next_fetch: got done=%b low=%0d halted_model=%b", dn, low, m_halted); end
    n_cmp++; if (bus.ir_out !== m_ir || bus.pc_out !== m_pc) begin n_bad++; $display("FAIL halt_next_state: got ir=%h pc=%h want %h %h", bus.ir_out, bus.pc_out, m_ir, m_pc); end
    do_load(32'h0000_0020);
    step();
    n_cmp++; if (bus.pc_out !== m_pc || bus.halted !== m_halted || bus.imem_read_en_ !== 1'b1) begin n_bad++; $display("FAIL halt_load: got pc=%h halted=%b rden=%b want %h %b 1", bus.pc_out, bus.halted, bus.imem_read_en_, m_pc, m_halted); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    for (int i = 3; i < 351; i += 4) if (mem[i][7:2] == 6'h3F) mem[i][7] = 1'b0;
    test_reset();
    test_basic_fetch();
    test_branch_load();
    test_stall();
    test_faults();
    test_ignored_in_flight();
    test_random();
    test_reset_mid_fetch();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
